// File: rtl/video_timing_pkg.sv
// Shared types, default 480x272 timing and the timing validation rule
// for the video timing generator.
package video_timing_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  localparam int DEF_HA = 480;
  localparam int DEF_HB = 43;
  localparam int DEF_HF = 8;
  localparam int DEF_HS = 10;
  localparam int DEF_VA = 272;
  localparam int DEF_VB = 4;
  localparam int DEF_VF = 12;
  localparam int DEF_VS = 10;

  // A timing is usable when both axes have a non-empty sync and active
  // region, both totals fit their counters, and the line start leaves room
  // for the pixel request to lead DE by the look-ahead distance.
  function automatic logic timing_valid(
    input int unsigned ha, hb, hf, hs,
    input int unsigned va, vb, vf, vs,
    input int unsigned hw, vw, look_ahead
  );
    if (ha == 0 || hs == 0 || va == 0 || vs == 0) return 1'b0;
    if ((ha + hb + hf + hs) >= (32'd1 << hw)) return 1'b0;
    if ((va + vb + vf + vs) >= (32'd1 << vw)) return 1'b0;
    if ((hs + hb) < look_ahead) return 1'b0;
    return 1'b1;
  endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Configuration/status bus of the video timing generator.
//   iEnable, iH*/iV* timing fields, iUnderflowClr : driven by the CSR side
//   oBusy, oCfgErr, oUnderflow, oFrameCnt          : status back to the CSR side
interface video_timing_gen_if #(
  parameter int pHW  = 11,
  parameter int pVW  = 10,
  parameter int pFcW = 16
);
  logic            iEnable;
  logic [pHW-1:0]  iHA, iHB, iHF, iHS;
  logic [pVW-1:0]  iVA, iVB, iVF, iVS;
  logic            iUnderflowClr;
  logic            oBusy;
  logic            oCfgErr;
  logic            oUnderflow;
  logic [pFcW-1:0] oFrameCnt;

  modport master (
    output iEnable, iHA, iHB, iHF, iHS, iVA, iVB, iVF, iVS, iUnderflowClr,
    input  oBusy, oCfgErr, oUnderflow, oFrameCnt
  );

  modport slave (
    input  iEnable, iHA, iHB, iHF, iHS, iVA, iVB, iVF, iVS, iUnderflowClr,
    output oBusy, oCfgErr, oUnderflow, oFrameCnt
  );
endinterface

// File: rtl/video_axis_counter.sv
// One timing axis: counts Sync, Back, Active, Front in that order.
//   clr/adv            : hold at zero / step by one (wraps after the last position)
//   *_len              : region lengths
//   cnt, wrap          : current position, position is the last of the axis
//   in_sync, in_active : position lies in the sync / active region
module video_axis_counter #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         adv,
  input  logic [W-1:0] sync_len,
  input  logic [W-1:0] back_len,
  input  logic [W-1:0] act_len,
  input  logic [W-1:0] front_len,
  output logic [W-1:0] cnt,
  output logic         wrap,
  output logic         in_sync,
  output logic         in_active
);
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] last_pos, act_start, act_end;

  always_comb begin
    last_pos  = sync_len + back_len + act_len + front_len - W'(1);
    act_start = sync_len + back_len;
    act_end   = act_start + act_len;
    wrap      = (cnt_q == last_pos);
    in_sync   = (cnt_q < sync_len);
    in_active = (cnt_q >= act_start) && (cnt_q < act_end);
    cnt_d     = cnt_q;
    if (clr)      cnt_d = '0;
    else if (adv) cnt_d = wrap ? '0 : cnt_q + W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
endmodule

// File: rtl/video_timing_gen.sv
// Programmable video timing generator (pixel clock domain).
//   iVCLK, iVRST : pixel clock, async active-high reset
//   cfg          : timing fields, enable, underflow clear, status
//   iPixVd       : FIFO pixel valid, checked while DE is active
//   oHS/oVS/oDE  : syncs and data enable at parameter polarity
//   oFE, oLS     : last clock of frame, first clock of line
//   oPixReq      : FIFO read request leading DE by pLookAhead
//   oHpos, oVpos : counter position the outputs describe
//
// state | meaning
// IDLE  | counters held at 0, outputs inactive, waiting for a valid enable
// RUN   | frames repeat; shadow timing reloaded at each frame wrap
// DRAIN | enable dropped mid-frame; finish the frame, then IDLE
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int   pHW        = 11,
  parameter int   pVW        = 10,
  parameter int   pLookAhead = 2,
  parameter int   pFcW       = 16,
  parameter logic pHsPol     = 1'b0,
  parameter logic pVsPol     = 1'b0,
  parameter logic pDePol     = 1'b1
) (
  input  logic              iVCLK,
  input  logic              iVRST,
  video_timing_gen_if.slave cfg,
  input  logic              iPixVd,
  output logic              oHS,
  output logic              oVS,
  output logic              oDE,
  output logic              oFE,
  output logic              oLS,
  output logic              oPixReq,
  output logic [pHW-1:0]    oHpos,
  output logic [pVW-1:0]    oVpos
);
  state_e state_q, state_d;
  logic   running, frame_wrap, cfg_ok, load;

  logic [pHW-1:0] s_ha_q, s_hb_q, s_hf_q, s_hs_q;
  logic [pVW-1:0] s_va_q, s_vb_q, s_vf_q, s_vs_q;

  logic [pHW-1:0] hcnt, pr_start, pr_end;
  logic [pVW-1:0] vcnt;
  logic           h_wrap, h_sync, h_act, v_wrap, v_sync, v_act;

  logic hsync_q, vsync_q, de_q, fe_q, ls_q, preq_q, busy_q, cfg_err_q, uflow_q;
  logic hsync_d, vsync_d, de_d, fe_d, ls_d, preq_d, busy_d, cfg_err_d, uflow_d;
  logic [pHW-1:0]  hpos_q, hpos_d;
  logic [pVW-1:0]  vpos_q, vpos_d;
  logic [pFcW-1:0] fcnt_q, fcnt_d;

  video_axis_counter #(.W(pHW)) u_hcnt (
    .clk(iVCLK), .rst(iVRST), .clr(!running), .adv(running),
    .sync_len(s_hs_q), .back_len(s_hb_q), .act_len(s_ha_q), .front_len(s_hf_q),
    .cnt(hcnt), .wrap(h_wrap), .in_sync(h_sync), .in_active(h_act)
  );

  video_axis_counter #(.W(pVW)) u_vcnt (
    .clk(iVCLK), .rst(iVRST), .clr(!running), .adv(running && h_wrap),
    .sync_len(s_vs_q), .back_len(s_vb_q), .act_len(s_va_q), .front_len(s_vf_q),
    .cnt(vcnt), .wrap(v_wrap), .in_sync(v_sync), .in_active(v_act)
  );

  always_comb begin
    running    = (state_q != IDLE);
    frame_wrap = running && h_wrap && v_wrap;
    cfg_ok     = timing_valid(32'(cfg.iHA), 32'(cfg.iHB), 32'(cfg.iHF), 32'(cfg.iHS),
                              32'(cfg.iVA), 32'(cfg.iVB), 32'(cfg.iVF), 32'(cfg.iVS),
                              pHW, pVW, pLookAhead);
    state_d    = state_q;
    load       = 1'b0;
    cfg_err_d  = cfg_err_q;
    case (state_q)
      IDLE: begin
        if (cfg.iEnable) begin
          if (cfg_ok) begin
            load    = 1'b1;
            state_d = RUN;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      default: begin
        if (frame_wrap) begin
          if (!cfg.iEnable) begin
            state_d = IDLE;
          end else begin
            state_d = RUN;
            if (cfg_ok) load = 1'b1;
            else        cfg_err_d = 1'b1;
          end
        end else begin
          state_d = cfg.iEnable ? RUN : DRAIN;
        end
      end
    endcase
    if (load) cfg_err_d = 1'b0;

    // Request window is the active window shifted left by the look-ahead;
    // validation guarantees HS+HB >= pLookAhead so the start cannot underflow.
    pr_start = s_hs_q + s_hb_q - pHW'(pLookAhead);
    pr_end   = pr_start + s_ha_q;

    hsync_d = running && h_sync;
    vsync_d = running && v_sync;
    de_d    = running && h_act && v_act;
    preq_d  = running && v_act && (hcnt >= pr_start) && (hcnt < pr_end);
    ls_d    = running && (hcnt == '0);
    fe_d    = frame_wrap;
    busy_d  = running;
    hpos_d  = hcnt;
    vpos_d  = vcnt;
    fcnt_d  = fe_d ? fcnt_q + pFcW'(1) : fcnt_q;
    uflow_d = (de_q && !iPixVd) || (uflow_q && !cfg.iUnderflowClr);
  end

  always_ff @(posedge iVCLK or posedge iVRST) begin
    if (iVRST) begin
      state_q   <= IDLE;
      s_ha_q    <= pHW'(DEF_HA);
      s_hb_q    <= pHW'(DEF_HB);
      s_hf_q    <= pHW'(DEF_HF);
      s_hs_q    <= pHW'(DEF_HS);
      s_va_q    <= pVW'(DEF_VA);
      s_vb_q    <= pVW'(DEF_VB);
      s_vf_q    <= pVW'(DEF_VF);
      s_vs_q    <= pVW'(DEF_VS);
      hsync_q   <= 1'b0;
      vsync_q   <= 1'b0;
      de_q      <= 1'b0;
      fe_q      <= 1'b0;
      ls_q      <= 1'b0;
      preq_q    <= 1'b0;
      busy_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      uflow_q   <= 1'b0;
      hpos_q    <= '0;
      vpos_q    <= '0;
      fcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      if (load) begin
        s_ha_q <= cfg.iHA;
        s_hb_q <= cfg.iHB;
        s_hf_q <= cfg.iHF;
        s_hs_q <= cfg.iHS;
        s_va_q <= cfg.iVA;
        s_vb_q <= cfg.iVB;
        s_vf_q <= cfg.iVF;
        s_vs_q <= cfg.iVS;
      end
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      de_q      <= de_d;
      fe_q      <= fe_d;
      ls_q      <= ls_d;
      preq_q    <= preq_d;
      busy_q    <= busy_d;
      cfg_err_q <= cfg_err_d;
      uflow_q   <= uflow_d;
      hpos_q    <= hpos_d;
      vpos_q    <= vpos_d;
      fcnt_q    <= fcnt_d;
    end
  end

  assign oHS            = hsync_q ? pHsPol : ~pHsPol;
  assign oVS            = vsync_q ? pVsPol : ~pVsPol;
  assign oDE            = de_q ? pDePol : ~pDePol;
  assign oFE            = fe_q;
  assign oLS            = ls_q;
  assign oPixReq        = preq_q;
  assign oHpos          = hpos_q;
  assign oVpos          = vpos_q;
  assign cfg.oBusy      = busy_q;
  assign cfg.oCfgErr    = cfg_err_q;
  assign cfg.oUnderflow = uflow_q;
  assign cfg.oFrameCnt  = fcnt_q;
endmodule
